// File: rtl/mvm_seq_pkg.sv
// Shared types for the matrix-vector job sequencer: FSM states, command word
// layout and default widths.
package mvm_seq_pkg;

  localparam int DATAW_DEF = 512;
  localparam int DESTW_DEF = 12;
  localparam int CMDD_DEF  = 256;
  localparam int RESW_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_RX = 3'd4,
    S_DONE    = 3'd5
  } seq_state_e;

  // Same bit order as the command memory word: {tlast, tdest, tdata}.
  typedef struct packed {
    logic                 tlast;
    logic [DESTW_DEF-1:0] tdest;
    logic [DATAW_DEF-1:0] tdata;
  } seq_cmd_t;

endpackage

// File: rtl/mvm_sequencer.sv
// Streams a pre-loaded command program into the NoC ingress, then counts
// result flits from the egress and pulses done when the job is complete.
module mvm_sequencer
  import mvm_seq_pkg::*;
#(
  parameter int DATAW    = DATAW_DEF,
  parameter int DESTW    = DESTW_DEF,
  parameter int CMDD     = CMDD_DEF,
  parameter int CMDADDRW = $clog2(CMDD),
  parameter int RESW     = RESW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CMDADDRW:0]         num_cmds,
  input  logic [RESW-1:0]           num_results,
  output logic                      busy,
  output logic                      done,
  output logic                      rx_overflow,
  output logic [RESW-1:0]           result_count,
  output logic [DATAW-1:0]          result_data,
  output logic [CMDADDRW-1:0]       cmd_addr,
  input  logic [DESTW+DATAW:0]      cmd_rdata,
  output logic                      axis_tx_tvalid,
  output logic [DATAW-1:0]          axis_tx_tdata,
  output logic [DESTW-1:0]          axis_tx_tdest,
  output logic                      axis_tx_tlast,
  input  logic                      axis_tx_tready,
  input  logic                      axis_rx_tvalid,
  input  logic [DATAW-1:0]          axis_rx_tdata,
  input  logic [DESTW-1:0]          axis_rx_tdest,
  input  logic                      axis_rx_tlast,
  output logic                      axis_rx_tready,
  output seq_state_e                dbg_state
);

  // Handshake: a tx beat transfers on a cycle where axis_tx_tvalid and
  // axis_tx_tready are both high; tvalid never drops and tx payload never
  // changes until that cycle. The rx side is always ready, so every
  // axis_rx_tvalid cycle is a transfer.

  localparam logic [CMDADDRW:0] PTR_ONE = 1;
  localparam logic [RESW-1:0]   RES_ONE = 1;

  seq_state_e          state_q, state_d;
  logic [CMDADDRW:0]   cmd_ptr_q, cmd_ptr_d;
  logic [CMDADDRW:0]   num_cmds_q, num_cmds_d;
  logic [RESW-1:0]     num_results_q, num_results_d;
  logic [RESW-1:0]     result_count_q, result_count_d;
  logic [DATAW-1:0]    result_data_q, result_data_d;
  logic                rx_overflow_q, rx_overflow_d;
  logic [DATAW-1:0]    tx_data_q, tx_data_d;
  logic [DESTW-1:0]    tx_dest_q, tx_dest_d;
  logic                tx_last_q, tx_last_d;

  // The node is the known destination, so the egress routing fields are ignored.
  logic rx_unused;
  assign rx_unused = ^{axis_rx_tdest, axis_rx_tlast};

  always_comb begin
    state_d        = state_q;
    cmd_ptr_d      = cmd_ptr_q;
    num_cmds_d     = num_cmds_q;
    num_results_d  = num_results_q;
    result_count_d = result_count_q;
    result_data_d  = result_data_q;
    rx_overflow_d  = rx_overflow_q;
    tx_data_d      = tx_data_q;
    tx_dest_d      = tx_dest_q;
    tx_last_d      = tx_last_q;

    // Receive path runs ahead of the FSM so SEND/WAIT_RX see this cycle's flit.
    if (axis_rx_tvalid) begin
      if (state_q == S_IDLE) begin
        rx_overflow_d = 1'b1;
      end else begin
        result_count_d = (result_count_q == '1) ? result_count_q
                                                : result_count_q + RES_ONE;
        result_data_d  = axis_rx_tdata;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_cmds_d     = num_cmds;
          num_results_d  = num_results;
          cmd_ptr_d      = '0;
          result_count_d = '0;
          rx_overflow_d  = axis_rx_tvalid;
          if (num_cmds != '0)         state_d = S_FETCH;
          else if (num_results != '0) state_d = S_WAIT_RX;
          else                        state_d = S_DONE;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tx_last_d = cmd_rdata[DESTW+DATAW];
        tx_dest_d = cmd_rdata[DATAW +: DESTW];
        tx_data_d = cmd_rdata[DATAW-1:0];
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (axis_tx_tready) begin
          cmd_ptr_d = cmd_ptr_q + PTR_ONE;
          if (cmd_ptr_d < num_cmds_q)               state_d = S_FETCH;
          else if (result_count_d >= num_results_q) state_d = S_DONE;
          else                                      state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        if (result_count_d >= num_results_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cmd_ptr_q      <= '0;
      num_cmds_q     <= '0;
      num_results_q  <= '0;
      result_count_q <= '0;
      result_data_q  <= '0;
      rx_overflow_q  <= 1'b0;
      tx_data_q      <= '0;
      tx_dest_q      <= '0;
      tx_last_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_ptr_q      <= cmd_ptr_d;
      num_cmds_q     <= num_cmds_d;
      num_results_q  <= num_results_d;
      result_count_q <= result_count_d;
      result_data_q  <= result_data_d;
      rx_overflow_q  <= rx_overflow_d;
      tx_data_q      <= tx_data_d;
      tx_dest_q      <= tx_dest_d;
      tx_last_q      <= tx_last_d;
    end
  end

  assign busy           = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                          (state_q == S_SEND)  || (state_q == S_WAIT_RX);
  assign done           = (state_q == S_DONE);
  assign rx_overflow    = rx_overflow_q;
  assign result_count   = result_count_q;
  assign result_data    = result_data_q;
  assign cmd_addr       = cmd_ptr_q[CMDADDRW-1:0];
  assign axis_tx_tvalid = (state_q == S_SEND);
  assign axis_tx_tdata  = tx_data_q;
  assign axis_tx_tdest  = tx_dest_q;
  assign axis_tx_tlast  = tx_last_q;
  assign axis_rx_tready = 1'b1;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Directed bench for mvm_sequencer: expected tx beats and done pulses are
// queued by the driver and popped by an independent monitor.
module tb_mvm_sequencer;
  import mvm_seq_pkg::*;

  localparam int DATAW    = DATAW_DEF;
  localparam int DESTW    = DESTW_DEF;
  localparam int CMDD     = CMDD_DEF;
  localparam int CMDADDRW = $clog2(CMDD);
  localparam int RESW     = RESW_DEF;
  localparam int TXW      = 1 + DESTW + DATAW;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CMDADDRW:0]   num_cmds;
  logic [RESW-1:0]     num_results;
  logic                busy, done, rx_overflow;
  logic [RESW-1:0]     result_count;
  logic [DATAW-1:0]    result_data;
  logic [CMDADDRW-1:0] cmd_addr;
  logic [TXW-1:0]      cmd_rdata;
  logic                axis_tx_tvalid, axis_tx_tlast, axis_tx_tready;
  logic [DATAW-1:0]    axis_tx_tdata;
  logic [DESTW-1:0]    axis_tx_tdest;
  logic                axis_rx_tvalid, axis_rx_tlast, axis_rx_tready;
  logic [DATAW-1:0]    axis_rx_tdata;
  logic [DESTW-1:0]    axis_rx_tdest;
  seq_state_e          dbg_state;

  mvm_sequencer #(
    .DATAW(DATAW), .DESTW(DESTW), .CMDD(CMDD), .CMDADDRW(CMDADDRW), .RESW(RESW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_cmds(num_cmds),
    .num_results(num_results), .busy(busy), .done(done),
    .rx_overflow(rx_overflow), .result_count(result_count),
    .result_data(result_data), .cmd_addr(cmd_addr), .cmd_rdata(cmd_rdata),
    .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tdata(axis_tx_tdata),
    .axis_tx_tdest(axis_tx_tdest), .axis_tx_tlast(axis_tx_tlast),
    .axis_tx_tready(axis_tx_tready), .axis_rx_tvalid(axis_rx_tvalid),
    .axis_rx_tdata(axis_rx_tdata), .axis_rx_tdest(axis_rx_tdest),
    .axis_rx_tlast(axis_rx_tlast), .axis_rx_tready(axis_rx_tready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / command memory ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [TXW-1:0] mem [CMDD];
  always @(posedge clk) cmd_rdata <= mem[cmd_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [TXW-1:0]  exp_q[$];
  int              exp_cyc_q[$];
  int              exp_done_q[$];
  logic [RESW-1:0] exp_rc_q[$];

  task automatic check(input string name, input logic [TXW-1:0] act,
                       input logic [TXW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  logic           hold_valid = 1'b0;
  logic [TXW-1:0] held_word;

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_valid) begin
        check("tx_hold_valid", TXW'(axis_tx_tvalid), TXW'(1));
        check("tx_hold_word", {axis_tx_tlast, axis_tx_tdest, axis_tx_tdata}, held_word);
      end
      if (axis_tx_tvalid && axis_tx_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected at cycle %0d: got beat dest %0h, required none",
                   cyc, axis_tx_tdest);
        end else begin
          logic [TXW-1:0] w;
          int c;
          w = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("tx_word", {axis_tx_tlast, axis_tx_tdest, axis_tx_tdata}, w);
          check("tx_cycle", TXW'(cyc), TXW'(c));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected at cycle %0d: got done=1, required 0", cyc);
        end else begin
          int c;
          logic [RESW-1:0] r;
          c = exp_done_q.pop_front();
          r = exp_rc_q.pop_front();
          check("done_cycle", TXW'(cyc), TXW'(c));
          check("done_result_count", TXW'(result_count), TXW'(r));
          check("done_busy_low", TXW'(busy), TXW'(0));
        end
      end
    end
    hold_valid = axis_tx_tvalid && !axis_tx_tready && !rst;
    held_word  = {axis_tx_tlast, axis_tx_tdest, axis_tx_tdata};
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic load_prog(input int n, input logic [DESTW-1:0] dest, input int base);
    seq_cmd_t c;
    for (int i = 0; i < n; i++) begin
      c.tlast = (i == n - 1);
      c.tdest = dest;
      c.tdata = {16{32'(base + i)}};
      mem[i]  = c;
    end
  endtask

  task automatic push_beat(input int idx, input int at_cyc);
    exp_q.push_back(mem[idx]);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic push_done(input int at_cyc, input int rc);
    exp_done_q.push_back(at_cyc);
    exp_rc_q.push_back(RESW'(rc));
  endtask

  task automatic do_start(input int nc, input int nr, output int s);
    start       = 1'b1;
    num_cmds    = (CMDADDRW+1)'(nc);
    num_results = RESW'(nr);
    s           = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic rx_flit(input logic [DATAW-1:0] d);
    axis_rx_tvalid = 1'b1;
    axis_rx_tdata  = d;
    tick();
    axis_rx_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done at cycle %0d: got no done within %0d cycles", cyc, budget);
    end
    tick();
  endtask

  task automatic check_reset_values();
    check("rst_busy", TXW'(busy), TXW'(0));
    check("rst_done", TXW'(done), TXW'(0));
    check("rst_overflow", TXW'(rx_overflow), TXW'(0));
    check("rst_result_count", TXW'(result_count), TXW'(0));
    check("rst_result_data", TXW'(result_data), TXW'(0));
    check("rst_cmd_addr", TXW'(cmd_addr), TXW'(0));
    check("rst_tx_tvalid", TXW'(axis_tx_tvalid), TXW'(0));
    check("rst_tx_word", {axis_tx_tlast, axis_tx_tdest, axis_tx_tdata}, TXW'(0));
    check("rst_rx_tready", TXW'(axis_rx_tready), TXW'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    logic [DATAW-1:0] d1, d2, d3;
    for (int i = 0; i < CMDD; i++) mem[i] = '0;
    rst            = 1'b1;
    start          = 1'b0;
    num_cmds       = '0;
    num_results    = '0;
    axis_tx_tready = 1'b1;
    axis_rx_tvalid = 1'b0;
    axis_rx_tdata  = '0;
    axis_rx_tdest  = '0;
    axis_rx_tlast  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_values();

    // Basic job: 4 beats every 3 cycles, one late result.
    load_prog(4, 12'h001, 32'h0000_0100);
    do_start(4, 1, s);
    check("basic_busy", TXW'(busy), TXW'(1));
    push_beat(0, s + 3);
    push_beat(1, s + 6);
    push_beat(2, s + 9);
    push_beat(3, s + 12);
    push_done(s + 23, 1);
    wait_cyc(s + 22);
    d1 = {16{32'hCAFE_0001}};
    rx_flit(d1);
    wait_done(10);
    check("basic_result_data", TXW'(result_data), TXW'(d1));

    // Back-pressure on beat 2 for 5 cycles.
    load_prog(3, 12'h2A5, 32'h0000_1000);
    do_start(3, 0, s);
    push_beat(0, s + 3);
    push_beat(1, s + 11);
    push_beat(2, s + 14);
    push_done(s + 15, 0);
    wait_cyc(s + 6);
    axis_tx_tready = 1'b0;
    wait_cyc(s + 8);
    check("bp_cmd_addr_stall", TXW'(cmd_addr), TXW'(1));
    wait_cyc(s + 11);
    axis_tx_tready = 1'b1;
    tick();
    check("bp_cmd_addr_next", TXW'(cmd_addr), TXW'(2));
    wait_done(20);

    // Early results: both flits arrive while beat 2 is stalled in SEND.
    load_prog(2, 12'h055, 32'h0000_2000);
    do_start(2, 2, s);
    push_beat(0, s + 3);
    push_beat(1, s + 8);
    push_done(s + 9, 2);
    wait_cyc(s + 6);
    axis_tx_tready = 1'b0;
    d1 = {16{32'hBEEF_0001}};
    d2 = {16{32'hBEEF_0002}};
    axis_rx_tvalid = 1'b1;
    axis_rx_tdata  = d1;
    tick();
    axis_rx_tdata  = d2;
    tick();
    axis_rx_tvalid = 1'b0;
    axis_tx_tready = 1'b1;
    check("early_state_send", TXW'(dbg_state), TXW'(S_SEND));
    check("early_count", TXW'(result_count), TXW'(2));
    wait_done(5);
    check("early_result_data", TXW'(result_data), TXW'(d2));

    // Zero commands, zero results: done right after start.
    do_start(0, 0, s);
    push_done(s + 1, 0);
    wait_done(5);

    // Zero commands, three results.
    do_start(0, 3, s);
    push_done(s + 7, 3);
    wait_cyc(s + 2);
    rx_flit({16{32'h0000_00A1}});
    wait_cyc(s + 4);
    rx_flit({16{32'h0000_00A2}});
    check("zero3_busy", TXW'(busy), TXW'(1));
    check("zero3_count", TXW'(result_count), TXW'(2));
    wait_cyc(s + 6);
    d3 = {16{32'h0000_00A3}};
    rx_flit(d3);
    wait_done(5);

    // Flit while idle, then a start while busy.
    rx_flit({16{32'hDEAD_DEAD}});
    check("idle_overflow", TXW'(rx_overflow), TXW'(1));
    check("idle_count_held", TXW'(result_count), TXW'(3));
    check("idle_data_held", TXW'(result_data), TXW'(d3));
    load_prog(1, 12'h3FF, 32'h0000_3000);
    do_start(1, 0, s);
    check("start_clears_overflow", TXW'(rx_overflow), TXW'(0));
    push_beat(0, s + 3);
    push_done(s + 4, 0);
    start       = 1'b1;
    num_cmds    = (CMDADDRW+1)'(5);
    num_results = RESW'(7);
    tick();
    start = 1'b0;
    wait_done(10);

    // Reset while a beat is stalled in SEND, then replay from address 0.
    load_prog(3, 12'h0F0, 32'h0000_4000);
    axis_tx_tready = 1'b0;
    do_start(3, 1, s);
    wait_cyc(s + 4);
    check("mid_send_tvalid", TXW'(axis_tx_tvalid), TXW'(1));
    rst = 1'b1;
    tick();
    check_reset_values();
    rst = 1'b0;
    axis_tx_tready = 1'b1;
    do_start(2, 0, s);
    check("replay_cmd_addr", TXW'(cmd_addr), TXW'(0));
    push_beat(0, s + 3);
    push_beat(1, s + 6);
    push_done(s + 7, 0);
    wait_done(20);

    repeat (3) tick();
    check("tx_queue_empty", TXW'(exp_q.size()), TXW'(0));
    check("done_queue_empty", TXW'(exp_done_q.size()), TXW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
